prog_loader: RTL

Byte-stream program loader with its own byte-addressed instruction store. It accepts a valid/ready byte stream, writes the bytes sequentially into a 2**AWIDTH-byte memory starting at a programmable base address, and signals completion. A combinational 32-bit little-endian fetch port serves the core. The block is the write-side counterpart of the instruction fetch path: it fills the program store, and `busy` holds the core in reset while a load is in progress.

---
 rtl/loader_pkg.sv | 6 +
 rtl/byte_ram.sv | 20 ++
 rtl/prog_loader.sv | 69 ++++++
 3 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the program loader
package loader_pkg;
    localparam int MEMSIZE = 256;
    localparam int BWIDTH = 8;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_e;
endpackage

// File: rtl/byte_ram.sv
// byte_ram: byte-wide write, 4-byte little-endian wrapped combinational read
module byte_ram
    import loader_pkg::*;
#(
    parameter int AWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AWIDTH-1:0]     waddr,
    input  logic [BWIDTH-1:0]     wdata,
    input  logic [AWIDTH-1:0]     raddr,
    output logic [4*BWIDTH-1:0]   rdata
);
    logic [2**AWIDTH-1:0][BWIDTH-1:0] mem;
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    always_comb
        rdata = {mem[raddr + AWIDTH'(3)], mem[raddr + AWIDTH'(2)],
                 mem[raddr + AWIDTH'(1)], mem[raddr]};
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams bytes into the program store and pulses done when the load completes
module prog_loader
    import loader_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   length,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    input  logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] rdata
);
    loader_state_e     state;
    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH:0]   cnt;
    logic              we;
    assign we = s_valid & s_ready;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wptr    <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    wptr    <= base_addr;
                    cnt     <= length;
                    busy    <= 1'b1;
                    state   <= (length != '0) ? LOAD : DONE;
                    s_ready <= (length != '0);
                    done    <= (length == '0);
                end
                LOAD: if (we) begin
                    wptr <= wptr + AWIDTH'(1);
                    cnt  <= cnt - (AWIDTH+1)'(1);
                    if (cnt == (AWIDTH+1)'(1)) begin
                        state   <= DONE;
                        s_ready <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    byte_ram #(.AWIDTH(AWIDTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .wdata (s_data),
        .raddr (addr),
        .rdata (rdata)
    );
endmodule
